// File: rtl/single_float_to_fixed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : single_float_to_fixed_pkg
// Purpose  : Shared definitions for the iterative float-to-fixed converter:
//            the FSM state encoding and the default float/fixed geometry.
//            The geometry constants are the defaults for the converter's
//            parameters. The converter derives its field positions,
//            all-ones exponent and saturation values from those parameters.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package single_float_to_fixed_pkg;

  // Converter sequencing: accept -> classify -> iterative shift -> sign/pack.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_PACK   = 2'd3
  } state_t;

  // Default IEEE-754 single-precision geometry.
  localparam int          c_dwidth         = 32;
  localparam int          c_exponent_width = 8;
  localparam logic [7:0]  c_bias           = 8'd127;

  // Default fixed-point output geometry (Q15.16).
  localparam int          c_fixed_width    = 32;
  localparam int          c_frac_bits      = 16;

endpackage : single_float_to_fixed_pkg
`default_nettype wire

// File: rtl/single_float_to_fixed.sv
`default_nettype none
// ============================================================================
// Module   : single_float_to_fixed
// Purpose  : Iterative IEEE-754 single-precision to signed fixed-point
//            converter. The mantissa is denormalised by shifting one bit per
//            cycle into a FIXED_WIDTH two's-complement word with FRAC_BITS
//            fraction bits. Out-of-range values, Inf and NaN saturate or are
//            flagged.
// Ports    : clk       in   1            clock, all state on posedge
//            rst       in   1            synchronous active-high reset
//            a         in   DWIDTH       float operand, sampled in IDLE
//            ip_ready  in   1            request strobe, ignored when busy
//            valid     out  1            one-cycle result pulse
//            fixed_out out  FIXED_WIDTH  signed result, held until next one
//            overflow  out  1            saturation/NaN flag for fixed_out
// Revision : 1.0  initial release
// ============================================================================
module single_float_to_fixed
  import single_float_to_fixed_pkg::*;
#(
  parameter int                        DWIDTH         = c_dwidth,
  parameter int                        EXPONENT_WIDTH = c_exponent_width,
  parameter logic [EXPONENT_WIDTH-1:0] BIAS           = c_bias,
  parameter int                        FIXED_WIDTH    = c_fixed_width,
  parameter int                        FRAC_BITS      = c_frac_bits
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DWIDTH-1:0]      a,
  input  logic                   ip_ready,
  output logic                   valid,
  output logic [FIXED_WIDTH-1:0] fixed_out,
  output logic                   overflow
);

  localparam int c_mw = DWIDTH - EXPONENT_WIDTH - 1;  // stored fraction bits
  localparam int c_sw = EXPONENT_WIDTH + 2;           // signed shift width

  localparam logic [EXPONENT_WIDTH-1:0] c_exp_ones = '1;
  localparam logic [FIXED_WIDTH-1:0]    c_sat_pos  = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0]    c_sat_neg  = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

  // Shift amount s = exp - BIAS - c_mw + FRAC_BITS. c_s_adj folds the constant
  // terms. c_s_hi is the largest left shift that keeps the (c_mw+1)-bit
  // mantissa inside FIXED_WIDTH. Right shifts beyond c_s_lo can only give 0.
  localparam logic signed [c_sw-1:0] c_s_adj = c_sw'(FRAC_BITS - c_mw);
  localparam logic signed [c_sw-1:0] c_s_hi  = c_sw'(FIXED_WIDTH - c_mw - 1);
  localparam logic signed [c_sw-1:0] c_s_lo  = c_sw'(-(c_mw + 1));

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic [EXPONENT_WIDTH-1:0] exp_q, exp_d;
  logic [c_mw:0]            man_q, man_d;
  logic [FIXED_WIDTH-1:0]   mag_q, mag_d;
  logic                     sat_q, sat_d;
  logic                     ovf_q, ovf_d;
  logic                     dir_q, dir_d;       // 1: shift left, 0: shift right
  logic [c_sw-1:0]          cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic [FIXED_WIDTH-1:0]   fixed_q, fixed_d;
  logic                     overflow_q, overflow_d;

  logic signed [c_sw-1:0]   w_s;
  logic [c_sw-1:0]          w_s_abs;
  logic                     w_frac_zero;

  always_comb begin
    w_s         = $signed({2'b00, exp_q}) - $signed({2'b00, BIAS}) + c_s_adj;
    w_s_abs     = w_s[c_sw-1] ? (-w_s) : w_s;
    w_frac_zero = (man_q[c_mw-1:0] == '0);
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    man_d      = man_q;
    mag_d      = mag_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    fixed_d    = fixed_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (ip_ready) begin
          sign_d  = a[DWIDTH-1];
          exp_d   = a[DWIDTH-2 -: EXPONENT_WIDTH];
          man_d   = {1'b1, a[c_mw-1:0]};
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        mag_d = '0;
        sat_d = 1'b0;
        ovf_d = 1'b0;
        dir_d = 1'b0;
        cnt_d = '0;
        if (exp_q == '0) begin
          // Zero and denormals are far below one LSB: result is 0.
        end else if (exp_q == c_exp_ones) begin
          // Inf saturates by sign; NaN yields 0. Both are flagged.
          ovf_d = 1'b1;
          sat_d = w_frac_zero;
        end else if (w_s > c_s_hi) begin
          sat_d = 1'b1;
          ovf_d = 1'b1;
        end else if (w_s == c_s_hi) begin
          // Only -2^(FIXED_WIDTH-1) itself is representable at this shift.
          sat_d = 1'b1;
          ovf_d = !(sign_q && w_frac_zero);
        end else if (w_s < c_s_lo) begin
          // Truncates to zero.
        end else begin
          mag_d = FIXED_WIDTH'(man_q);
          dir_d = !w_s[c_sw-1];
          cnt_d = w_s_abs;
        end
        state_d = (cnt_d != '0) ? ST_SHIFT : ST_PACK;
      end

      ST_SHIFT: begin
        mag_d = dir_q ? (mag_q << 1) : (mag_q >> 1);
        cnt_d = cnt_q - c_sw'(1);
        if (cnt_q == c_sw'(1)) begin
          state_d = ST_PACK;
        end
      end

      ST_PACK: begin
        if (sat_q) begin
          fixed_d = sign_q ? c_sat_neg : c_sat_pos;
        end else begin
          fixed_d = sign_q ? (-mag_q) : mag_q;
        end
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      man_q      <= '0;
      mag_q      <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      fixed_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      man_q      <= man_d;
      mag_q      <= mag_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      fixed_q    <= fixed_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid     = valid_q;
  assign fixed_out = fixed_q;
  assign overflow  = overflow_q;

endmodule : single_float_to_fixed
`default_nettype wire

// File: tb/tb_single_float_to_fixed.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_float_to_fixed
// Purpose  : Self-checking bench for single_float_to_fixed (Q15.16 output).
//            The driver issues requests and pushes reference results into a
//            scoreboard. A monitor pops and compares on every valid pulse.
// Ports    : none (testbench top)
// Revision : 1.0  initial release
// ============================================================================
module tb_single_float_to_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic        ip_ready;
  logic        valid;
  logic [31:0] fixed_out;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] fx;
    bit          ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  single_float_to_fixed #(
    .DWIDTH        (32),
    .EXPONENT_WIDTH(8),
    .BIAS          (8'd127),
    .FIXED_WIDTH   (32),
    .FRAC_BITS     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .ip_ready (ip_ready),
    .valid    (valid),
    .fixed_out(fixed_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
  endtask

  // Reference: value = m * 2^(exp-150) scaled by 2^16 = m * 2^s, truncated
  // toward zero, then range-checked against the signed 32-bit output.
  function automatic void ref_model(input logic [31:0] f, output logic [31:0] fx,
                                    output bit ovf, output int lat);
    int     e, s;
    bit     sg;
    longint m, mag, v;
    sg  = f[31];
    e   = int'(f[30:23]);
    m   = longint'({1'b1, f[22:0]});
    lat = 2;
    fx  = 32'h0;
    ovf = 1'b0;
    if (e == 255) begin
      ovf = 1'b1;
      if (f[22:0] == 23'h0) fx = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    if (e == 0) return;
    s = e - 127 - 23 + 16;
    if (s > 8)         mag = 64'sd1 <<< 40;
    else if (s >= 0)   mag = m <<< s;
    else if (s >= -40) mag = m >>> (-s);
    else               mag = 0;
    if (s >= -24 && s < 8) lat = 2 + ((s < 0) ? -s : s);
    v = sg ? -mag : mag;
    if (v > 64'sd2147483647) begin
      fx = 32'h7FFF_FFFF; ovf = 1'b1;
    end else if (v < -64'sd2147483648) begin
      fx = 32'h8000_0000; ovf = 1'b1;
    end else begin
      fx = v[31:0];
    end
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    if ($urandom_range(0, 9) < 8) f[30:23] = 8'($urandom_range(100, 150));
    return f;
  endfunction

  // Called at a negedge while the DUT is idle (after reset or in a valid
  // cycle). Returns at the negedge where valid is observed.
  task automatic issue(input logic [31:0] f, input bit garbage);
    exp_t e;
    int   lat;
    bit   seen;
    a        = f;
    ip_ready = 1'b1;
    ref_model(f, e.fx, e.ovf, lat);
    e.a   = f;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    ip_ready = garbage;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (garbage) a = $urandom;
      @(negedge clk);
    end
    if (!seen) check($sformatf("timeout a=%08h", f), {31'b0, valid}, 32'd1);
    if (!garbage) begin
      ip_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'b0, valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("fixed_out a=%08h", mon_e.a), fixed_out, mon_e.fx);
        check($sformatf("overflow a=%08h", mon_e.a), {31'b0, overflow}, {31'b0, mon_e.ovf});
        check($sformatf("latency a=%08h", mon_e.a), cyc, mon_e.due);
      end
    end
  end

  logic [31:0] dir_vec [14] = '{
    32'h3F80_0000, 32'hC020_0000, 32'h8000_0000, 32'h4780_0000,
    32'hC700_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
    32'h3580_0000, 32'h4700_0000, 32'h3700_0000, 32'h4680_0000,
    32'h46FF_FFFF, 32'hC6FF_FFFF
  };

  initial begin
    rst      = 1'b1;
    a        = 32'h0;
    ip_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_fixed_out", fixed_out, 32'd0);
    check("reset_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (dir_vec[i]) issue(dir_vec[i], 1'b0);

    // Back-to-back with ip_ready held and the operand changing every cycle.
    for (int i = 0; i < 40; i++) issue(rand_float(), 1'b1);
    ip_ready = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) issue(rand_float(), 1'b0);

    // Leave non-zero outputs and a set overflow flag, then reset mid-SHIFT.
    issue(32'hC020_0000, 1'b0);
    issue(32'h7F80_0000, 1'b0);
    a        = 32'h3F80_0000;
    ip_ready = 1'b1;
    @(negedge clk);
    ip_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset_valid", {31'b0, valid}, 32'd0);
    check("midop_reset_fixed_out", fixed_out, 32'd0);
    check("midop_reset_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(32'h3F80_0000, 1'b0);
    issue(32'hC020_0000, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_total);
    $fatal(1);
  end

endmodule : tb_single_float_to_fixed
`default_nettype wire
